// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue register stage feeding the ALU.
// Optional macro RV32M_DECODE_EN enables MUL/MULH/MULHSU/MULHU decode.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       fetch handshake; instr_in, pc_in payload
//   rs1_addr/rs2_addr       combinational regfile read addresses
//   rs1_data/rs2_data       same-cycle regfile read data
//   flush                   drop held and incoming instruction
//   out_valid/out_ready     execute handshake
//   pc_out, rs1_out, rs2_out, imm_out, alu_ctrl, mux1_ctrl,
//   mux2_ctrl, rd_addr, rd_we, illegal   registered issue payload
module alu_issue_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr_in,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] rs1_out,
    output logic [DATA_WIDTH-1:0] rs2_out,
    output logic [DATA_WIDTH-1:0] imm_out,
    output logic [FUNC_WIDTH-1:0] alu_ctrl,
    output logic                  mux1_ctrl,
    output logic                  mux2_ctrl,
    output logic [4:0]            rd_addr,
    output logic                  rd_we,
    output logic                  illegal
);

    typedef logic [FUNC_WIDTH-1:0] func_t;

    localparam func_t OP_ADD   = func_t'(0);
    localparam func_t OP_SUB   = func_t'(1);
    localparam func_t OP_SLL   = func_t'(2);
    localparam func_t OP_SLT   = func_t'(3);
    localparam func_t OP_SLTU  = func_t'(4);
    localparam func_t OP_XOR   = func_t'(5);
    localparam func_t OP_SRL   = func_t'(6);
    localparam func_t OP_SRA   = func_t'(7);
    localparam func_t OP_OR    = func_t'(8);
    localparam func_t OP_AND   = func_t'(9);
    localparam func_t OP_PASSB = func_t'(10);
`ifdef RV32M_DECODE_EN
    localparam func_t OP_MUL   = func_t'(11);
`endif

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;

    assign opcode   = instr_in[6:0];
    assign funct3   = instr_in[14:12];
    assign funct7   = instr_in[31:25];
    assign rd       = instr_in[11:7];
    assign rs1_addr = instr_in[19:15];
    assign rs2_addr = instr_in[24:20];

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_u = {instr_in[31:12], 12'b0};

    function automatic func_t base_op(input logic [2:0] f3);
        func_t r;
        unique case (f3)
            3'd0:    r = OP_ADD;
            3'd1:    r = OP_SLL;
            3'd2:    r = OP_SLT;
            3'd3:    r = OP_SLTU;
            3'd4:    r = OP_XOR;
            3'd5:    r = OP_SRL;
            3'd6:    r = OP_OR;
            default: r = OP_AND;
        endcase
        return r;
    endfunction

    func_t       d_alu;
    logic        d_mux1;
    logic        d_mux2;
    logic [31:0] d_imm;
    logic        d_bad;
    logic        d_wr;
    logic        n_alu_ok;
    logic        n_we;
    func_t       n_alu;
    logic        n_mux1;
    logic        n_mux2;
    logic [31:0] n_imm;

    always_comb begin
        d_alu  = OP_ADD;
        d_mux1 = 1'b0;
        d_mux2 = 1'b0;
        d_imm  = '0;
        d_bad  = 1'b0;
        d_wr   = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                d_wr = 1'b1;
                if (funct7 == F7_BASE) begin
                    d_alu = base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
                    d_alu = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
                    d_alu = OP_SRA;
`ifdef RV32M_DECODE_EN
                end else if (funct7 == F7_MULD && !funct3[2]) begin
                    d_alu = OP_MUL + func_t'(funct3);
`endif
                end else begin
                    d_bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                d_wr   = 1'b1;
                d_mux2 = 1'b1;
                d_imm  = imm_i;
                d_alu  = base_op(funct3);
                // Shift-immediates carry funct7 in imm[11:5].
                if (funct3 == 3'd1 && funct7 != F7_BASE) begin
                    d_bad = 1'b1;
                end else if (funct3 == 3'd5) begin
                    if (funct7 == F7_ALT)
                        d_alu = OP_SRA;
                    else if (funct7 != F7_BASE)
                        d_bad = 1'b1;
                end
            end
            OPC_LUI: begin
                d_wr   = 1'b1;
                d_alu  = OP_PASSB;
                d_mux2 = 1'b1;
                d_imm  = imm_u;
            end
            OPC_AUIPC: begin
                d_wr   = 1'b1;
                d_mux1 = 1'b1;
                d_mux2 = 1'b1;
                d_imm  = imm_u;
            end
            OPC_LOAD: begin
                d_wr   = 1'b1;
                d_mux2 = 1'b1;
                d_imm  = imm_i;
            end
            OPC_STORE: begin
                d_mux2 = 1'b1;
                d_imm  = imm_s;
            end
            default: d_bad = 1'b1;
        endcase
    end

    // Illegal encodings issue as a harmless ADD with no writeback.
    assign n_alu_ok = !d_bad;
    assign n_alu    = n_alu_ok ? d_alu  : OP_ADD;
    assign n_mux1   = n_alu_ok ? d_mux1 : 1'b0;
    assign n_mux2   = n_alu_ok ? d_mux2 : 1'b0;
    assign n_imm    = n_alu_ok ? d_imm  : 32'd0;
    assign n_we     = n_alu_ok && d_wr && (rd != 5'd0);

    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pc_out    <= '0;
            rs1_out   <= '0;
            rs2_out   <= '0;
            imm_out   <= '0;
            alu_ctrl  <= '0;
            mux1_ctrl <= 1'b0;
            mux2_ctrl <= 1'b0;
            rd_addr   <= '0;
            rd_we     <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (accept)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                pc_out    <= pc_in;
                rs1_out   <= rs1_data;
                rs2_out   <= rs2_data;
                imm_out   <= DATA_WIDTH'($signed(n_imm));
                alu_ctrl  <= n_alu;
                mux1_ctrl <= n_mux1;
                mux2_ctrl <= n_mux2;
                rd_addr   <= rd;
                rd_we     <= n_we;
                illegal   <= d_bad;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage.
// Directed cases followed by randomized traffic with back-pressure/flush.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic [31:0] imm_out;
    logic [4:0]  alu_ctrl;
    logic        mux1_ctrl;
    logic        mux2_ctrl;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;

    alu_issue_stage #(.DATA_WIDTH(32), .FUNC_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .imm_out(imm_out), .alu_ctrl(alu_ctrl),
        .mux1_ctrl(mux1_ctrl), .mux2_ctrl(mux2_ctrl),
        .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic        m1;
        logic        m2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    bit   m_valid = 0;

    localparam int BASE [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins,
                                   input logic [31:0] pc,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        int op, f3, f7;
        bit ok, wr;
        logic [11:0] i12;
        logic [11:0] s12;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        e.pc = pc; e.rs1 = a; e.rs2 = b; e.rd = ins[11:7];
        e.imm = 0; e.alu = 0; e.m1 = 0; e.m2 = 0;
        ok = 1; wr = 0;
        if (op == 'h33) begin
            wr = 1;
            if (f7 == 0) e.alu = 5'(BASE[f3]);
            else if (f7 == 'h20 && f3 == 0) e.alu = 1;
            else if (f7 == 'h20 && f3 == 5) e.alu = 7;
`ifdef RV32M_DECODE_EN
            else if (f7 == 1 && f3 < 4) e.alu = 5'(11 + f3);
`endif
            else ok = 0;
        end else if (op == 'h13) begin
            wr = 1; e.m2 = 1;
            e.imm = 32'($signed(i12));
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) begin
                ok = (f7 == 0) || (f7 == 'h20);
                e.alu = (f7 == 'h20) ? 5'd7 : 5'd6;
            end else begin
                e.alu = 5'(BASE[f3]);
            end
        end else if (op == 'h37) begin
            wr = 1; e.alu = 10; e.m2 = 1;
            e.imm = {ins[31:12], 12'h000};
        end else if (op == 'h17) begin
            wr = 1; e.m1 = 1; e.m2 = 1;
            e.imm = {ins[31:12], 12'h000};
        end else if (op == 'h03) begin
            wr = 1; e.m2 = 1;
            e.imm = 32'($signed(i12));
        end else if (op == 'h23) begin
            e.m2 = 1;
            e.imm = 32'($signed(s12));
        end else begin
            ok = 0;
        end
        e.ill = !ok;
        if (!ok) begin
            e.alu = 0; e.m1 = 0; e.m2 = 0; e.imm = 0;
        end
        e.we = ok && wr && (e.rd != 0);
        return e;
    endfunction

    // Monitor: compares the presented payload every valid cycle,
    // retiring the scoreboard entry when execute accepts it.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual=1 expected=0");
            end else begin
                me = q[0];
                chk("pc_out", pc_out, me.pc);
                chk("rs1_out", rs1_out, me.rs1);
                chk("rs2_out", rs2_out, me.rs2);
                chk("alu_ctrl", 32'(alu_ctrl), 32'(me.alu));
                chk("mux1", 32'(mux1_ctrl), 32'(me.m1));
                chk("mux2", 32'(mux2_ctrl), 32'(me.m2));
                chk("rd_we", 32'(rd_we), 32'(me.we));
                chk("illegal", 32'(illegal), 32'(me.ill));
                if (!me.ill) begin
                    chk("imm_out", imm_out, me.imm);
                    chk("rd_addr", 32'(rd_addr), 32'(me.rd));
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic drv(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b);
        in_valid = v; instr_in = ins; pc_in = pc;
        rs1_data = a; rs2_data = b;
    endtask

    // Called at posedge+1 with inputs set; predicts the coming edge.
    task automatic tick();
        bit er;
        #6;
        er = !m_valid || out_ready;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (in_valid) begin
            chk("rs1_addr", 32'(rs1_addr), 32'(instr_in[19:15]));
            chk("rs2_addr", 32'(rs2_addr), 32'(instr_in[24:20]));
        end
        if (flush) begin
            if (m_valid && !out_ready && q.size() > 0)
                void'(q.pop_front());
            m_valid = 0;
        end else if (in_valid && er) begin
            q.push_back(model(instr_in, pc_in, rs1_data, rs2_data));
            m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] r;
        logic [6:0]  op;
        logic [6:0]  f7;
        int k;
        r = $urandom;
        k = $urandom_range(0, 7);
        case (k)
            0, 1: op = 7'h33;
            2:    op = 7'h13;
            3:    op = 7'h37;
            4:    op = 7'h17;
            5:    op = 7'h03;
            6:    op = 7'h23;
            default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = r[31:25];
        endcase
        if (op == 7'h33 || op == 7'h13) r[31:25] = f7;
        r[6:0] = op;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1; flush = 0; out_ready = 1;
        idle();
        #2 rst_n = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_imm", imm_out, 0);
        chk("rst_alu", 32'(alu_ctrl), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;

        // ADDI x1,x2,-5
        drv(1, 32'hFFB10093, 32'h0, 32'd20, 32'd0);
        tick(); idle();
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_imm", imm_out, 32'hFFFFFFFB);
        chk("addi_rs1", rs1_out, 32'd20);
        chk("addi_alu", 32'(alu_ctrl), 0);
        chk("addi_mux2", 32'(mux2_ctrl), 1);
        chk("addi_rd", 32'(rd_addr), 1);
        chk("addi_we", 32'(rd_we), 1);
        tick();

        // SUB x3,x4,x5
        drv(1, 32'h405201B3, 32'h4, 32'd20, 32'd30);
        chk("sub_rs2_addr", 32'(rs2_addr), 5);
        tick(); idle();
        chk("sub_alu", 32'(alu_ctrl), 1);
        chk("sub_mux2", 32'(mux2_ctrl), 0);
        chk("sub_rd", 32'(rd_addr), 3);
        tick();

        // AUIPC x1,0x12345
        drv(1, 32'h12345097, 32'd10, 32'd0, 32'd0);
        tick(); idle();
        chk("auipc_alu", 32'(alu_ctrl), 0);
        chk("auipc_mux1", 32'(mux1_ctrl), 1);
        chk("auipc_mux2", 32'(mux2_ctrl), 1);
        chk("auipc_imm", imm_out, 32'h12345000);
        chk("auipc_pc", pc_out, 32'd10);
        tick();

        // MUL x1,x2,x3
        drv(1, 32'h023100B3, 32'h0, 32'd7, 32'd9);
        tick(); idle();
`ifdef RV32M_DECODE_EN
        chk("mul_alu", 32'(alu_ctrl), 11);
        chk("mul_ill", 32'(illegal), 0);
`else
        chk("mul_ill", 32'(illegal), 1);
        chk("mul_we", 32'(rd_we), 0);
        chk("mul_alu", 32'(alu_ctrl), 0);
`endif
        tick();

        drv(1, 32'h0000007F, 32'h0, 32'd1, 32'd2);
        tick(); idle();
        chk("opc7f_ill", 32'(illegal), 1);
        tick();

        // Back-pressure: second ADDI stalls behind the first.
        out_ready = 0;
        drv(1, 32'hFFB10093, 32'h100, 32'd1, 32'd2);
        tick();
        drv(1, 32'h06438313, 32'h104, 32'd3, 32'd4);
        tick();
        tick();
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_hold_imm", imm_out, 32'hFFFFFFFB);
        out_ready = 1;
        tick(); idle();
        chk("bp_second_imm", imm_out, 32'd100);
        chk("bp_second_rd", 32'(rd_addr), 6);
        tick();
        tick();

        // Flush against a held payload and a new request.
        out_ready = 0;
        drv(1, 32'h00A00513, 32'h200, 32'd0, 32'd0);
        tick();
        flush = 1;
        drv(1, 32'h00B00593, 32'h204, 32'd0, 32'd0);
        tick();
        flush = 0; idle();
        chk("flush_valid", 32'(out_valid), 0);
        tick();
        out_ready = 1;
        tick();

        // Reset during a stall.
        out_ready = 0;
        drv(1, 32'h12345097, 32'h300, 32'd5, 32'd6);
        tick(); idle();
        rst_n = 0;
        #1;
        chk("rst_stall_valid", 32'(out_valid), 0);
        chk("rst_stall_pc", pc_out, 0);
        chk("rst_stall_imm", imm_out, 0);
        chk("rst_stall_ready", 32'(in_ready), 1);
        q.delete();
        m_valid = 0;
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        out_ready = 1;

        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            drv(($urandom_range(0, 3) != 0), gen(), $urandom,
                $urandom, $urandom);
            tick();
        end

        flush = 0; out_ready = 1; idle();
        tick(); tick(); tick();
        chk("drain_empty", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
